// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: LEGv8 MEM stage - branch resolution, req/ack data-memory access,
// upstream stall and MEM/WB register load with sticky bus error reporting.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              isBranch_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              regWrite_in,
    input  logic              memToReg_in,
    input  logic [63:0]       shiftedProgramCounter_in,
    input  logic              ALUzero_in,
    input  logic [63:0]       ALUresult_in,
    input  logic [63:0]       writeDataMem_in,
    input  logic [4:0]        writeReg_in,
    output logic              stall_out,
    output logic              pcSrc_out,
    output logic [63:0]       branchTarget_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [63:0]       dmem_rdata,
    output logic              regWrite_out,
    output logic              memToReg_out,
    output logic [63:0]       readData_out,
    output logic [63:0]       ALUresult_out,
    output logic [4:0]        writeReg_out,
    output logic              bus_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

    stateT       state;
    logic [31:0] count;
    logic [63:0] rdataLatch;
    logic        timedOut;
    logic        access;
    logic        mis;
    logic        isLoad;
    logic        expire;

    assign access = memRead_in | memWrite_in;
    assign mis    = access & (ALUresult_in[2:0] != 3'd0);
    assign isLoad = memRead_in & ~memWrite_in;
    assign expire = (TIMEOUT > 0) && (count == 32'(TIMEOUT - 1));

    // Gated by reset so the pipe is released while reset is held.
    assign stall_out        = RESET_N & (((state == IDLE) & access & ~mis) | (state == ACCESS));
    assign pcSrc_out        = isBranch_in & ALUzero_in & ~stall_out;
    assign branchTarget_out = shiftedProgramCounter_in;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            count         <= '0;
            rdataLatch    <= '0;
            timedOut      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            regWrite_out  <= 1'b0;
            memToReg_out  <= 1'b0;
            readData_out  <= '0;
            ALUresult_out <= '0;
            writeReg_out  <= '0;
            bus_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access & ~mis) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= memWrite_in;
                        dmem_addr    <= ALUresult_in[ADDR_W-1:0];
                        dmem_wdata   <= writeDataMem_in;
                        count        <= '0;
                        timedOut     <= 1'b0;
                        regWrite_out <= 1'b0;
                        memToReg_out <= 1'b0;
                        state        <= ACCESS;
                    end else begin
                        regWrite_out  <= regWrite_in & ~(mis & isLoad);
                        memToReg_out  <= memToReg_in;
                        ALUresult_out <= ALUresult_in;
                        writeReg_out  <= writeReg_in;
                        readData_out  <= '0;
                        if (mis)
                            bus_error <= 1'b1;
                    end
                end
                ACCESS: begin
                    regWrite_out <= 1'b0;
                    memToReg_out <= 1'b0;
                    if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        rdataLatch <= dmem_we ? 64'd0 : dmem_rdata;
                        state      <= DONE;
                    end else if (expire) begin
                        dmem_req   <= 1'b0;
                        rdataLatch <= '0;
                        timedOut   <= 1'b1;
                        bus_error  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                DONE: begin
                    regWrite_out  <= regWrite_in & ~(timedOut & ~dmem_we);
                    memToReg_out  <= memToReg_in;
                    ALUresult_out <= ALUresult_in;
                    writeReg_out  <= writeReg_in;
                    readData_out  <= rdataLatch;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
